// File: rtl/perf_counter_bank.sv
// Purpose : bank of NCH independent WIDTH-bit event counters with per-channel
//           clear, load, compare-match pulse, sticky overflow and an indexed read port.
// Latency : counter, ovf and match update at the clock edge. The read port returns
//           the pre-edge value one cycle after rd_idx is presented.
// Backpressure : none. Every input is accepted every cycle.
//
// Ports:
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   evt, cnt_en, clr    per-channel event strobe, count enable, synchronous clear
//   wr_en, cmp_we       load counter / write compare register wr_idx with wr_data
//   rd_idx              channel for the registered read (rd_data, rd_ovf)
//   snap, rd_snap       capture all counters into shadows / read shadow instead of live
//   ovf, match, irq     sticky overflow flags, one-cycle match pulses, OR of match
//
// Optional build macro PERF_CNT_SNAPSHOT_EN adds the shadow registers. Without it,
// snap and rd_snap are accepted but have no effect.

module perf_counter_bank #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   evt,
    input  logic [NCH-1:0]   cnt_en,
    input  logic [NCH-1:0]   clr,
    input  logic             wr_en,
    input  logic             cmp_we,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDXW-1:0]  rd_idx,
    input  logic             snap,
    input  logic             rd_snap,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_ovf,
    output logic [NCH-1:0]   ovf,
    output logic [NCH-1:0]   match,
    output logic             irq
);

    logic [WIDTH-1:0] cnt_q   [NCH];
    logic [WIDTH-1:0] cnt_d   [NCH];
    logic [WIDTH-1:0] cmp_q   [NCH];
    logic [WIDTH-1:0] cmp_d   [NCH];
    logic [WIDTH-1:0] cnt_inc [NCH];
    logic [NCH-1:0]   wr_hit;
    logic [NCH-1:0]   ovf_q, ovf_d;
    logic [NCH-1:0]   match_q, match_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_ovf_q, rd_ovf_d;

`ifdef PERF_CNT_SNAPSHOT_EN
    logic [WIDTH-1:0] shadow_q [NCH];
    logic [WIDTH-1:0] shadow_d [NCH];
`else
    // The snapshot inputs are kept on the port list so both builds share one interface.
    logic unused_snap_inputs;
    assign unused_snap_inputs = snap ^ rd_snap;
`endif

    // Per-channel next state. Priority: clr > load > increment > hold.
    // The compare write is independent of the counter path, and the match
    // check always uses the compare value held before this edge.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i]  = (wr_idx == IDXW'(i));
            cnt_inc[i] = cnt_q[i] + WIDTH'(1);
            cnt_d[i]   = cnt_q[i];
            cmp_d[i]   = cmp_q[i];
            ovf_d[i]   = ovf_q[i];
            match_d[i] = 1'b0;

            if (clr[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (wr_en && wr_hit[i]) begin
                cnt_d[i] = wr_data;
            end else if (cnt_en[i] && evt[i]) begin
                cnt_d[i]   = cnt_inc[i];
                match_d[i] = (cnt_inc[i] == cmp_q[i]);
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                end
            end

            if (cmp_we && wr_hit[i]) begin
                cmp_d[i] = wr_data;
            end
        end
    end

`ifdef PERF_CNT_SNAPSHOT_EN
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
        end
    end
`endif

    // Read mux. Scanning the channels returns zero for an index past the
    // last channel without any out-of-range array access.
    always_comb begin
        rd_data_d = '0;
        rd_ovf_d  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_idx == IDXW'(i)) begin
`ifdef PERF_CNT_SNAPSHOT_EN
                rd_data_d = rd_snap ? shadow_q[i] : cnt_q[i];
`else
                rd_data_d = cnt_q[i];
`endif
                rd_ovf_d  = ovf_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                cmp_q[i] <= '1;
            end
            ovf_q     <= '0;
            match_q   <= '0;
            rd_data_q <= '0;
            rd_ovf_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                cmp_q[i] <= cmp_d[i];
            end
            ovf_q     <= ovf_d;
            match_q   <= match_d;
            rd_data_q <= rd_data_d;
            rd_ovf_q  <= rd_ovf_d;
        end
    end

`ifdef PERF_CNT_SNAPSHOT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end
`endif

    assign rd_data = rd_data_q;
    assign rd_ovf  = rd_ovf_q;
    assign ovf     = ovf_q;
    assign match   = match_q;
    assign irq     = |match_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Purpose : directed self-checking bench for perf_counter_bank (NCH=4, WIDTH=32).
// Latency : inputs change #1 after a rising edge; outputs are sampled at the same point.
// Backpressure : not applicable.

module tb_perf_counter_bank;

    logic        clk;
    logic        reset;
    logic [3:0]  evt;
    logic [3:0]  cnt_en;
    logic [3:0]  clr;
    logic        wr_en;
    logic        cmp_we;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data;
    logic [1:0]  rd_idx;
    logic        snap;
    logic        rd_snap;
    logic [31:0] rd_data;
    logic        rd_ovf;
    logic [3:0]  ovf;
    logic [3:0]  match;
    logic        irq;

    int checks = 0;
    int errors = 0;

    perf_counter_bank #(.WIDTH(32), .NCH(4), .IDXW(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .evt     (evt),
        .cnt_en  (cnt_en),
        .clr     (clr),
        .wr_en   (wr_en),
        .cmp_we  (cmp_we),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .snap    (snap),
        .rd_snap (rd_snap),
        .rd_data (rd_data),
        .rd_ovf  (rd_ovf),
        .ovf     (ovf),
        .match   (match),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        evt     = 4'b0000;
        cnt_en  = 4'b0000;
        clr     = 4'b0000;
        wr_en   = 1'b0;
        cmp_we  = 1'b0;
        wr_idx  = 2'd0;
        wr_data = 32'h0;
        snap    = 1'b0;
        rd_snap = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rd_idx = 2'd0;
        reset  = 1'b1;
        #1;
        tick();
        tick();

        // Reset state.
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_ovf", {31'h0, rd_ovf}, 32'h0);
        chk("rst_ovf", {28'h0, ovf}, 32'h0);
        chk("rst_match", {28'h0, match}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;

        // Cycle counter on channel 0: 10 counting edges, then hold.
        evt    = 4'b0001;
        cnt_en = 4'b0001;
        for (int k = 0; k < 10; k++) tick();
        chk("ch0_cycle10", rd_data, 32'd9);
        cnt_en = 4'b0000;
        tick();
        chk("ch0_cycle11", rd_data, 32'd10);
        rd_idx = 2'd1; tick();
        chk("ch1_idle", rd_data, 32'd0);
        rd_idx = 2'd2; tick();
        chk("ch2_idle", rd_data, 32'd0);
        rd_idx = 2'd3; tick();
        chk("ch3_idle", rd_data, 32'd0);
        chk("ovf_none", {28'h0, ovf}, 32'h0);

        // Wrap on channel 1.
        idle_inputs();
        wr_en = 1'b1; wr_idx = 2'd1; wr_data = 32'hFFFF_FFFE;
        rd_idx = 2'd1;
        tick();
        wr_en = 1'b0;
        evt = 4'b0010; cnt_en = 4'b0010;
        tick();
        chk("wrap_rd0", rd_data, 32'hFFFF_FFFE);
        chk("wrap_ovf_pre", {28'h0, ovf}, 32'h0);
        tick();
        chk("wrap_rd1", rd_data, 32'hFFFF_FFFF);
        chk("wrap_ovf_set", {28'h0, ovf}, 32'h2);
        tick();
        chk("wrap_rd2", rd_data, 32'h0);
        cnt_en = 4'b0000;
        tick();
        chk("wrap_rd3", rd_data, 32'h1);
        chk("wrap_rd_ovf", {31'h0, rd_ovf}, 32'h1);
        chk("wrap_ovf_held", {28'h0, ovf}, 32'h2);
        clr = 4'b0010;
        tick();
        clr = 4'b0000;
        chk("clr_ovf", {28'h0, ovf}, 32'h0);
        tick();
        chk("clr_rd", rd_data, 32'h0);
        chk("clr_rd_ovf", {31'h0, rd_ovf}, 32'h0);

        // Compare match on channel 2.
        idle_inputs();
        cmp_we = 1'b1; wr_idx = 2'd2; wr_data = 32'd5;
        tick();
        cmp_we = 1'b0;
        evt = 4'b0100; cnt_en = 4'b0100;
        for (int k = 0; k < 4; k++) tick();
        chk("match_before", {28'h0, match}, 32'h0);
        tick();
        chk("match_at5", {28'h0, match}, 32'h4);
        chk("irq_at5", {31'h0, irq}, 32'h1);
        tick();
        chk("match_after", {28'h0, match}, 32'h0);
        chk("irq_after", {31'h0, irq}, 32'h0);
        cnt_en = 4'b0000;
        wr_en = 1'b1; wr_idx = 2'd2; wr_data = 32'd5;
        tick();
        wr_en = 1'b0;
        chk("load_nomatch", {28'h0, match}, 32'h0);
        // Counter 2 is 5, cmp 5: increment and cmp write together compare with old cmp.
        cnt_en = 4'b0100; cmp_we = 1'b1; wr_data = 32'd6;
        tick();
        cmp_we = 1'b0; cnt_en = 4'b0000;
        chk("old_cmp_nomatch", {28'h0, match}, 32'h0);
        rd_idx = 2'd2;
        tick();
        chk("ch2_val", rd_data, 32'd6);

        // Priority on channel 3.
        idle_inputs();
        rd_idx = 2'd3;
        wr_en = 1'b1; wr_idx = 2'd3; wr_data = 32'd20;
        evt = 4'b1000; cnt_en = 4'b1000;
        tick();
        idle_inputs();
        tick();
        chk("load_over_inc", rd_data, 32'd20);
        clr = 4'b1000;
        wr_en = 1'b1; wr_idx = 2'd3; wr_data = 32'd77;
        evt = 4'b1000; cnt_en = 4'b1000;
        tick();
        idle_inputs();
        tick();
        chk("clr_over_all", rd_data, 32'd0);

        // Reset mid-count with a sticky overflow pending.
        wr_en = 1'b1; wr_idx = 2'd1; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_en = 1'b0;
        evt = 4'b1111; cnt_en = 4'b1111;
        rd_idx = 2'd1;
        for (int k = 0; k < 3; k++) tick();
        chk("pre_rst_ovf", {28'h0, ovf}, 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_rd", rd_data, 32'h0);
        chk("mid_rst_rd_ovf", {31'h0, rd_ovf}, 32'h0);
        chk("mid_rst_ovf", {28'h0, ovf}, 32'h0);
        chk("mid_rst_match", {28'h0, match}, 32'h0);
        rd_idx = 2'd0;
        for (int k = 0; k < 3; k++) tick();
        chk("resume_rd", rd_data, 32'd2);
        // Channel 2 passes 6 here; the compare register was reset to all-ones.
        for (int k = 0; k < 3; k++) tick();
        chk("resume_rd6", rd_data, 32'd5);
        chk("resume_nomatch", {28'h0, match}, 32'h0);

        // Snapshot: channel 0 at 100, snap, 20 more counts.
        idle_inputs();
        clr = 4'b1111;
        tick();
        clr = 4'b0000;
        wr_en = 1'b1; wr_idx = 2'd0; wr_data = 32'd100;
        tick();
        wr_en = 1'b0;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        evt = 4'b0001; cnt_en = 4'b0001;
        for (int k = 0; k < 20; k++) tick();
        cnt_en = 4'b0000;
        rd_idx = 2'd0; rd_snap = 1'b1;
        tick();
`ifdef PERF_CNT_SNAPSHOT_EN
        chk("snap_read", rd_data, 32'd100);
`else
        chk("snap_ignored", rd_data, 32'd120);
`endif
        rd_snap = 1'b0;
        tick();
        chk("live_read", rd_data, 32'd120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised bank of NCH independent event counters, each WIDTH bits wide.
- Successor to the single free-running cycle counter in the MCU datapath.
- Adds per-channel enable, clear, load, compare-match pulse, sticky overflow and an indexed registered read port.
- Channel 0 is normally wired with evt[0]=1 so it acts as the core cycle counter. Other channels count instruction retire, memory accesses, stalls, etc.

Parameters:
WIDTH, 32, bit width of each counter, compare register and read data
NCH, 4, number of counter channels (1..16)
IDXW, 2, channel index width; must equal clog2(NCH), minimum 1

Ports:
clk  in  1  single clock, rising-edge
reset  in  1  synchronous, active-high reset
evt  in  NCH  per-channel event strobe, sampled each clk
cnt_en  in  NCH  per-channel count enable
clr  in  NCH  per-channel synchronous clear
wr_en  in  1  load counter wr_idx with wr_data
cmp_we  in  1  write compare register wr_idx with wr_data
wr_idx  in  IDXW  target channel for wr_en/cmp_we
wr_data  in  WIDTH  load/compare data
rd_idx  in  IDXW  channel selected for read
snap  in  1  snapshot strobe (see Optional Feature)
rd_snap  in  1  read snapshot instead of live value (see Optional Feature)
rd_data  out  WIDTH  registered read data
rd_ovf  out  1  registered sticky-overflow flag of rd_idx
ovf  out  NCH  sticky overflow flags
match  out  NCH  one-cycle compare-match pulses
irq  out  1  OR of all match bits, combinational from match

Behaviour:
- Reset (clk edge with reset=1):
  - All counters = 0.
  - Compare registers = all-ones.
  - ovf = 0, match = 0, rd_data = 0, rd_ovf = 0, snapshot registers = 0.
- Per channel i, priority at each clk edge: reset > clr[i] > load (wr_en && wr_idx==i) > increment (cnt_en[i] && evt[i]) > hold.
- Increment adds 1, modulo 2^WIDTH.
- Wrap (all-ones to 0 by increment) sets ovf[i]. ovf[i] stays set until clr[i] or reset.
  - A load never sets or clears ovf.
  - clr[i] zeroes both the counter and ovf[i].
- match[i]: registered. High for exactly the one cycle after an edge at which an increment produced a value equal to cmp[i].
  - Loads and clears never generate match.
  - Increment and cmp write to the same channel in the same cycle: compare uses the old cmp value.
- cmp_we and wr_en together with the same wr_idx: both take effect.
- Read latency is 1 cycle:
  - rd_data(t+1) = value of counter[rd_idx(t)] as held during cycle t, i.e. before the update at that edge.
  - rd_ovf is aligned the same way.
  - rd_idx >= NCH returns rd_data=0, rd_ovf=0.
  - wr_idx >= NCH writes nothing.
- Reset asserted mid-count overrides all other inputs that cycle. Counting resumes on the first edge with reset=0.
- No combinational path from any input to rd_data, rd_ovf, ovf or match. irq is combinational from match only.

Optional Feature:
- Macro: PERF_CNT_SNAPSHOT_EN
- Defined:
  - snap=1 copies all NCH live counter values (pre-update values of that edge) into shadow registers in one cycle.
  - With rd_snap=1, rd_data returns shadow[rd_idx] with the same 1-cycle latency. rd_ovf still reports live ovf.
  - Shadow registers are reset to 0.
- Not defined:
  - No shadow registers are built.
  - snap and rd_snap are ignored; ports remain present so the interface is identical.
  - rd_data always returns live values.

Test Plan:
- Reset, then evt=4'b0001, cnt_en=4'b0001 for 10 cycles, rd_idx=0 -> rd_data reads 9 on cycle 10 and 10 on cycle 11; other channels read 0; ovf=0.
- Load channel 1 with 32'hFFFF_FFFE, then increment 3 times -> counter goes FFFF_FFFF, 0, 1; ovf[1] set on the wrap edge and held; clr[1] -> counter 0, ovf[1]=0.
- cmp of channel 2 = 5, count from 0 -> match[2] and irq high for exactly one cycle, after the edge producing 5; loading 5 directly produces no match.
- Same cycle clr[3], load on channel 3 and evt[3] -> counter 0. Load plus evt -> loaded value, not value+1.
- Assert reset for one cycle mid-count on all channels -> all outputs 0 on the next cycle; counting resumes from 0.
- With PERF_CNT_SNAPSHOT_EN: channel 0 at 100, pulse snap, wait 20 cycles, read with rd_snap=1 -> 100; rd_snap=0 -> live value 120.
